// File: rtl/div_ratio_detector.sv
// div_ratio_detector: measures high/low width and period of div_clk in clk cycles, reports duty symmetry, lock, err and stuck.
// Optional `DIV_DET_SYNC_EN adds a 2-flop synchronizer in front of the sampling flop.
module div_ratio_detector #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_clk,
  output logic [CNT_W:0]   ratio,
  output logic [CNT_W-1:0] high_w,
  output logic [CNT_W-1:0] low_w,
  output logic             symmetric,
  output logic             period_vld,
  output logic             locked,
  output logic             err,
  output logic             stuck
);
  localparam logic [CNT_W-1:0] SAT  = '1;
  localparam logic [3:0]       LOCK = 4'(LOCK_CNT);
  typedef enum logic [1:0] {S_WAIT, S_MEAS, S_LOCK} state_t;
  state_t state_q, state_d;
  logic samp, in_s_q, prev_q;
  logic [CNT_W-1:0] run_q, run_d, hi_cap_q, hi_cap_d, high_q, high_d, low_q, low_d;
  logic [CNT_W:0] ratio_q, ratio_d, new_ratio;
  logic [3:0] match_q, match_d, match_nx;
  logic have_hi_q, have_hi_d, sym_q, sym_d, vld_q, vld_d, lock_q, lock_d;
  logic err_q, err_d, stuck_q, stuck_d;
  logic rise, fall, edge_w, sat_w, same_w;
`ifdef DIV_DET_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], div_clk};
  assign samp = sync_q[1];
`else
  assign samp = div_clk;
`endif
  assign rise      = in_s_q & ~prev_q;
  assign fall      = ~in_s_q & prev_q;
  assign edge_w    = rise | fall;
  assign sat_w     = (run_q == SAT) & ~edge_w;
  assign run_d     = edge_w ? CNT_W'(1) : (run_q == SAT ? run_q : run_q + 1'b1);
  assign new_ratio = {1'b0, hi_cap_q} + {1'b0, run_q};
  // match_q == 0 marks the first period after S_WAIT, which never counts as a match
  assign same_w    = (match_q != 4'd0) && (new_ratio == ratio_q);
  assign match_nx  = same_w ? (match_q == LOCK ? LOCK : match_q + 4'd1) : 4'd1;
  always_comb begin
    state_d   = state_q;
    hi_cap_d  = hi_cap_q;
    have_hi_d = have_hi_q;
    match_d   = match_q;
    ratio_d   = ratio_q;
    high_d    = high_q;
    low_d     = low_q;
    sym_d     = sym_q;
    vld_d     = 1'b0;
    lock_d    = lock_q;
    err_d     = 1'b0;
    stuck_d   = stuck_q & ~edge_w;
    if (sat_w) begin
      stuck_d   = 1'b1;
      lock_d    = 1'b0;
      match_d   = 4'd0;
      have_hi_d = 1'b0;
      state_d   = S_WAIT;
    end else if (state_q == S_WAIT) begin
      if (rise) begin
        state_d   = S_MEAS;
        have_hi_d = 1'b0;
      end
    end else if (fall) begin
      hi_cap_d  = run_q;
      have_hi_d = 1'b1;
    end else if (rise && have_hi_q) begin
      ratio_d   = new_ratio;
      high_d    = hi_cap_q;
      low_d     = run_q;
      sym_d     = hi_cap_q == run_q;
      vld_d     = 1'b1;
      have_hi_d = 1'b0;
      match_d   = match_nx;
      if (state_q == S_LOCK && !same_w) begin
        err_d   = 1'b1;
        lock_d  = 1'b0;
        state_d = S_MEAS;
      end else if (match_nx == LOCK) begin
        lock_d  = 1'b1;
        state_d = S_LOCK;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_WAIT;
      in_s_q    <= 1'b0;
      prev_q    <= 1'b0;
      run_q     <= '0;
      hi_cap_q  <= '0;
      have_hi_q <= 1'b0;
      match_q   <= 4'd0;
      ratio_q   <= '0;
      high_q    <= '0;
      low_q     <= '0;
      sym_q     <= 1'b0;
      vld_q     <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_s_q    <= samp;
      prev_q    <= in_s_q;
      run_q     <= run_d;
      hi_cap_q  <= hi_cap_d;
      have_hi_q <= have_hi_d;
      match_q   <= match_d;
      ratio_q   <= ratio_d;
      high_q    <= high_d;
      low_q     <= low_d;
      sym_q     <= sym_d;
      vld_q     <= vld_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      stuck_q   <= stuck_d;
    end
  assign ratio      = ratio_q;
  assign high_w     = high_q;
  assign low_w      = low_q;
  assign symmetric  = sym_q;
  assign period_vld = vld_q;
  assign locked     = lock_q;
  assign err        = err_q;
  assign stuck      = stuck_q;
endmodule
